audio_mix_sched: RTL and testbench

Sample-rate scheduler and 4-source mixer that feeds the `left_in`/`right_in` inputs of the I2S/SPDIF/sigma-delta audio output stage. It generates a 48/96 kHz sample tick from the system clock with a fractional accumulator, polls up to four sound sources in fixed order over a req/ack handshake, and sums their stereo samples with saturation. It outputs one held stereo sample per tick. Missing, late and overrun conditions are reported on sticky flags.

---
 rtl/audio_mix_sched_if.sv | 38 +++
 rtl/audio_mix_sched.sv | 208 ++++++++++++++++++++
 tb/tb_audio_mix_sched.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_mix_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : audio_mix_sched_if                                            |
// | Purpose  : Source-side bus of the audio mix scheduler: per-source        |
// |            enables, one-hot request / acknowledge handshake and the      |
// |            packed stereo sample lanes (source i at [i*16 +: 16]).        |
// | Signals  : src_en  [3:0]  per-source enable          (source -> mixer)   |
// |            src_req [3:0]  one-hot sample request     (mixer  -> source)  |
// |            src_ack [3:0]  acknowledge, data valid    (source -> mixer)   |
// |            src_l   [63:0] left samples, signed       (source -> mixer)   |
// |            src_r   [63:0] right samples, signed      (source -> mixer)   |
// | Modports : master = mixer side, slave = sound-source side                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface audio_mix_sched_if;
  logic [3:0]  src_en;
  logic [3:0]  src_req;
  logic [3:0]  src_ack;
  logic [63:0] src_l;
  logic [63:0] src_r;

  modport master (
    input  src_en,
    output src_req,
    input  src_ack,
    input  src_l,
    input  src_r
  );

  modport slave (
    output src_en,
    input  src_req,
    output src_ack,
    output src_l,
    output src_r
  );
endinterface
`default_nettype wire

// File: rtl/audio_mix_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : audio_mix_sched                                               |
// | Purpose  : 48/96 kHz sample-tick generator (fractional accumulator) and  |
// |            4-source stereo mixer. Each tick polls the enabled sources in |
// |            fixed order over a req/ack handshake, sums with saturation    |
// |            and presents one held stereo sample. Timeouts and dropped     |
// |            ticks are reported on sticky flags.                           |
// | Ports    : clk, reset_n (sync, active low), sample_rate (0=48k, 1=96k),  |
// |            mute, src (audio_mix_sched_if.master), left_out/right_out,    |
// |            out_valid, sample_tick, timeout_err[3:0], overrun             |
// | Params   : CLK_RATE (Hz), TIMEOUT (max request cycles, 1..65535)        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module audio_mix_sched #(
  parameter int unsigned CLK_RATE = 50000000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  input  wire logic          sample_rate,
  input  wire logic          mute,
  audio_mix_sched_if.master  src,
  output logic signed [15:0] left_out,
  output logic signed [15:0] right_out,
  output logic               out_valid,
  output logic               sample_tick,
  output logic [3:0]         timeout_err,
  output logic               overrun
);

  localparam logic [31:0]        c_clk_rate     = 32'(CLK_RATE);
  localparam logic [31:0]        c_inc_48k      = 32'd48000;
  localparam logic [31:0]        c_inc_96k      = 32'd96000;
  // Timer holds (WAIT cycles - 1), so the last allowed cycle is TIMEOUT-1.
  localparam logic [15:0]        c_timeout_last = 16'(TIMEOUT - 1);
  localparam logic signed [17:0] c_pos_max      = 18'sd32767;
  localparam logic signed [17:0] c_neg_min      = -18'sd32768;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WAIT = 2'd2,
    ST_SUM  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- tick gen
  logic [31:0] r_cnt;
  logic        r_tick;
  logic [32:0] w_cnt_sum;
  logic        w_cnt_wrap;

  // One spare bit so the compare is safe for any CLK_RATE near 2^32.
  assign w_cnt_sum  = {1'b0, r_cnt} + {1'b0, (sample_rate ? c_inc_96k : c_inc_48k)};
  assign w_cnt_wrap = (w_cnt_sum >= {1'b0, c_clk_rate});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_cnt_wrap;
      r_cnt  <= w_cnt_wrap ? (w_cnt_sum[31:0] - c_clk_rate) : w_cnt_sum[31:0];
    end
  end

  // -------------------------------------------------------------- mixer FSM
  state_t             r_state,   w_state_nx;
  logic [1:0]         r_idx,     w_idx_nx;
  logic signed [17:0] r_accl,    w_accl_nx;
  logic signed [17:0] r_accr,    w_accr_nx;
  logic [3:0]         r_req,     w_req_nx;
  logic [15:0]        r_timer,   w_timer_nx;
  logic               r_pending, w_pending_nx;
  logic               r_overrun, w_overrun_nx;
  logic [3:0]         r_terr,    w_terr_nx;
  logic signed [15:0] r_left,    w_left_nx;
  logic signed [15:0] r_right,   w_right_nx;
  logic               r_valid,   w_valid_nx;
  logic               w_advance;

  logic [15:0] w_slice_l;
  logic [15:0] w_slice_r;

  assign w_slice_l = src.src_l[{r_idx, 4'b0000} +: 16];
  assign w_slice_r = src.src_r[{r_idx, 4'b0000} +: 16];

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > c_pos_max)      return 16'sh7fff;
    else if (v < c_neg_min) return 16'sh8000;
    else                    return v[15:0];
  endfunction

  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_accl_nx    = r_accl;
    w_accr_nx    = r_accr;
    w_req_nx     = r_req;
    w_timer_nx   = r_timer;
    w_pending_nx = r_pending;
    w_overrun_nx = r_overrun;
    w_terr_nx    = r_terr;
    w_left_nx    = r_left;
    w_right_nx   = r_right;
    w_valid_nx   = 1'b0;
    w_advance    = 1'b0;

    // A tick that cannot start a mix right away is queued once; a second
    // one arriving while the queue is full is lost.
    if (r_tick) begin
      if (r_pending)                w_overrun_nx = 1'b1;
      else if (r_state != ST_IDLE)  w_pending_nx = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (r_tick || r_pending) begin
          w_accl_nx    = '0;
          w_accr_nx    = '0;
          w_idx_nx     = 2'd0;
          w_pending_nx = 1'b0;
          w_state_nx   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (src.src_en[r_idx]) begin
          w_req_nx   = 4'b0001 << r_idx;
          w_timer_nx = '0;
          w_state_nx = ST_WAIT;
        end else begin
          w_advance  = 1'b1;
        end
      end
      ST_WAIT: begin
        // Ack is checked first so an ack on the final cycle beats the timeout.
        if (src.src_ack[r_idx]) begin
          w_accl_nx = r_accl + $signed({{2{w_slice_l[15]}}, w_slice_l});
          w_accr_nx = r_accr + $signed({{2{w_slice_r[15]}}, w_slice_r});
          w_req_nx  = '0;
          w_advance = 1'b1;
        end else if (r_timer == c_timeout_last) begin
          w_req_nx         = '0;
          w_terr_nx[r_idx] = 1'b1;
          w_advance        = 1'b1;
        end else begin
          w_timer_nx = r_timer + 16'd1;
        end
      end
      ST_SUM: begin
        w_left_nx  = mute ? 16'sd0 : sat16(r_accl);
        w_right_nx = mute ? 16'sd0 : sat16(r_accr);
        w_valid_nx = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase

    if (w_advance) begin
      if (r_idx == 2'd3) begin
        w_state_nx = ST_SUM;
      end else begin
        w_idx_nx   = r_idx + 2'd1;
        w_state_nx = ST_SCAN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_accl    <= '0;
      r_accr    <= '0;
      r_req     <= '0;
      r_timer   <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_terr    <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_accl    <= w_accl_nx;
      r_accr    <= w_accr_nx;
      r_req     <= w_req_nx;
      r_timer   <= w_timer_nx;
      r_pending <= w_pending_nx;
      r_overrun <= w_overrun_nx;
      r_terr    <= w_terr_nx;
      r_left    <= w_left_nx;
      r_right   <= w_right_nx;
      r_valid   <= w_valid_nx;
    end
  end

  assign src.src_req  = r_req;
  assign left_out     = r_left;
  assign right_out    = r_right;
  assign out_valid    = r_valid;
  assign sample_tick  = r_tick;
  assign timeout_err  = r_terr;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_audio_mix_sched                                            |
// | Purpose  : Self-checking bench for audio_mix_sched. Two instances:       |
// |            dut_a (TIMEOUT=8) for rate, mix, saturation, mute, timeout    |
// |            and randomized mixes; dut_b (TIMEOUT=200) for overrun and     |
// |            mid-transaction reset. CLK_RATE is scaled to 4.8 MHz so one   |
// |            "millisecond" is 4800 cycles (100 / 50 cycles per tick).      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_audio_mix_sched;
  localparam int CLK_RATE_TB = 4800000;
  localparam int TIMEOUT_A   = 8;
  localparam int TIMEOUT_B   = 200;
  localparam int MS_CYCLES   = CLK_RATE_TB / 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ----------------------------------------------------------------- dut_a
  logic               rst_a_n, rate_a, mute_a;
  logic signed [15:0] a_left, a_right;
  logic               a_valid, a_tick, a_ovr;
  logic [3:0]         a_terr;
  audio_mix_sched_if  a_if ();

  audio_mix_sched #(.CLK_RATE(CLK_RATE_TB), .TIMEOUT(TIMEOUT_A)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .sample_rate(rate_a), .mute(mute_a), .src(a_if),
    .left_out(a_left), .right_out(a_right), .out_valid(a_valid),
    .sample_tick(a_tick), .timeout_err(a_terr), .overrun(a_ovr)
  );

  // ----------------------------------------------------------------- dut_b
  logic               rst_b_n, rate_b, mute_b;
  logic signed [15:0] b_left, b_right;
  logic               b_valid, b_tick, b_ovr;
  logic [3:0]         b_terr;
  audio_mix_sched_if  b_if ();

  audio_mix_sched #(.CLK_RATE(CLK_RATE_TB), .TIMEOUT(TIMEOUT_B)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .sample_rate(rate_b), .mute(mute_b), .src(b_if),
    .left_out(b_left), .right_out(b_right), .out_valid(b_valid),
    .sample_tick(b_tick), .timeout_err(b_terr), .overrun(b_ovr)
  );

  // --------------------------------------------- source responder for dut_a
  // Source i acks after dly[i] extra cycles of its request (0 = same cycle
  // the request is seen); any dly >= TIMEOUT_A means it never acks.
  // spur[] drives acks on lines that are never requested.
  int         sl [4];
  int         sr [4];
  int         dly [4];
  int         a_wcnt [4];
  logic [3:0] en, spur, a_ack;
  logic [3:0] exp_terr_a;

  always @(posedge clk)
    for (int i = 0; i < 4; i++) a_wcnt[i] <= a_if.src_req[i] ? a_wcnt[i] + 1 : 0;

  always_comb begin
    a_ack = '0;
    for (int i = 0; i < 4; i++)
      a_ack[i] = (a_if.src_req[i] && (a_wcnt[i] == dly[i])) || spur[i];
  end
  assign a_if.src_ack = a_ack;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic apply_cfg();
    a_if.src_en = en;
    for (int i = 0; i < 4; i++) begin
      a_if.src_l[i*16 +: 16] = 16'(sl[i]);
      a_if.src_r[i*16 +: 16] = 16'(sr[i]);
    end
  endtask

  // Waits for the next tick on dut_a, follows the mix to out_valid and
  // compares latency, outputs, flags and request pattern with the model.
  task automatic run_mix(input string tag);
    int         n, lat, exp_lat, sum_l, sum_r, bad_hot;
    int         hi [4];
    int         exp_hi [4];
    logic [3:0] seq [$];
    logic [3:0] exp_seq [$];
    logic [3:0] prev;
    logic [15:0] got_p, exp_p;

    exp_lat = 2; sum_l = 0; sum_r = 0;
    for (int i = 0; i < 4; i++) begin
      exp_hi[i] = 0;
      hi[i]     = 0;
      if (en[i]) begin
        exp_seq.push_back(4'b0001 << i);
        if (dly[i] < TIMEOUT_A) begin
          exp_lat  += dly[i] + 2;
          exp_hi[i] = dly[i] + 1;
          sum_l    += sl[i];
          sum_r    += sr[i];
        end else begin
          exp_lat  += TIMEOUT_A + 1;
          exp_hi[i] = TIMEOUT_A;
          exp_terr_a[i] = 1'b1;
        end
      end else begin
        exp_lat += 1;
      end
    end

    n = 0;
    while (a_tick !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":tick_wait"}, 64'(a_tick), 64'd1);

    prev = '0; lat = 0; bad_hot = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!$onehot0(a_if.src_req)) bad_hot++;
      for (int i = 0; i < 4; i++) if (a_if.src_req[i]) hi[i]++;
      if (a_if.src_req != 4'd0 && a_if.src_req != prev) seq.push_back(a_if.src_req);
      prev = a_if.src_req;
    end while (a_valid !== 1'b1 && lat < 200);

    got_p = '0; exp_p = '0;
    foreach (seq[k])     got_p = {got_p[11:0], seq[k]};
    foreach (exp_seq[k]) exp_p = {exp_p[11:0], exp_seq[k]};

    check({tag, ":latency"},   64'(lat),        64'(exp_lat));
    check({tag, ":left"},      64'(a_left),     64'(mute_a ? 0 : sat16(sum_l)));
    check({tag, ":right"},     64'(a_right),    64'(mute_a ? 0 : sat16(sum_r)));
    check({tag, ":terr"},      64'(a_terr),     64'(exp_terr_a));
    check({tag, ":overrun"},   64'(a_ovr),      64'd0);
    check({tag, ":req_count"}, 64'(seq.size()), 64'(exp_seq.size()));
    check({tag, ":req_seq"},   64'(got_p),      64'(exp_p));
    check({tag, ":onehot"},    64'(bad_hot),    64'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s:req_hi%0d", tag, i), 64'(hi[i]), 64'(exp_hi[i]));
  endtask

  initial begin
    int n, nt, nv, nz;

    rst_a_n = 1'b0; rate_a = 1'b0; mute_a = 1'b0;
    rst_b_n = 1'b0; rate_b = 1'b1; mute_b = 1'b0;
    en = '0; spur = '0; exp_terr_a = '0;
    for (int i = 0; i < 4; i++) begin sl[i] = 0; sr[i] = 0; dly[i] = 0; end
    apply_cfg();
    b_if.src_en = 4'b0001; b_if.src_ack = '0; b_if.src_l = '0; b_if.src_r = '0;

    // ------------------------------------------------------ reset values
    repeat (3) @(negedge clk);
    check("rst:src_req", 64'(a_if.src_req), 64'd0);
    check("rst:left",    64'(a_left),       64'd0);
    check("rst:right",   64'(a_right),      64'd0);
    check("rst:valid",   64'(a_valid),      64'd0);
    check("rst:tick",    64'(a_tick),       64'd0);
    check("rst:flags",   64'({a_terr, a_ovr}), 64'd0);

    // ---------------------------------------------- rate: 48 kHz window
    rst_a_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (a_tick !== 1'b1 && n < 300);
    check("rate:first_tick", 64'(n), 64'd100);
    nt = 0; nv = 0; nz = 0;
    for (int c = 0; c < MS_CYCLES; c++) begin
      if (a_tick)  nt++;
      if (a_valid) begin nv++; if (a_left !== 16'sd0 || a_right !== 16'sd0) nz++; end
      @(negedge clk);
    end
    check("rate48:ticks",  64'(nt), 64'd48);
    check("rate48:valids", 64'(nv), 64'd48);
    check("rate48:zero",   64'(nz), 64'd0);

    // ---------------------------------------------- rate: 96 kHz window
    rate_a = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (a_tick !== 1'b1 && n < 300);
    check("rate96:first_interval_le", 64'(n <= CLK_RATE_TB / 96000), 64'd1);
    nt = 0; nv = 0; nz = 0;
    for (int c = 0; c < MS_CYCLES; c++) begin
      if (a_tick)  nt++;
      if (a_valid) begin nv++; if (a_left !== 16'sd0 || a_right !== 16'sd0) nz++; end
      @(negedge clk);
    end
    check("rate96:ticks",  64'(nt), 64'd96);
    check("rate96:valids", 64'(nv), 64'd96);
    check("rate96:zero",   64'(nz), 64'd0);
    repeat (20) @(negedge clk);
    rate_a = 1'b0;

    // ------------------------------------------------------------- mix
    en = 4'b1111;
    sl = '{1000, -200, 300, 4};
    sr = '{-5, 7, 100, -1000};
    dly = '{0, 0, 0, 0};
    apply_cfg();
    run_mix("mix");

    // ------------------------------------------------------ saturation
    sl = '{32000, 32000, 32000, 32000};
    sr = '{-32768, -32768, -32768, -32768};
    apply_cfg();
    run_mix("sat");
    mute_a = 1'b1;
    run_mix("mute");
    mute_a = 1'b0;

    // --------------------------------------------------------- timeout
    sl = '{100, 100, 100, 100};
    sr = '{-100, -100, -100, -100};
    dly = '{0, 0, 255, 0};
    apply_cfg();
    run_mix("timeout");
    dly = '{0, 0, 7, 0};
    run_mix("ack_last");

    // ---------------------------------------------- randomized mixes
    for (int k = 0; k < 24; k++) begin
      rate_a = 1'($urandom_range(0, 1));
      mute_a = ($urandom_range(0, 7) == 0);
      en     = 4'($urandom);
      spur   = ~en & 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 5))
          0: dly[i] = 0;
          1: dly[i] = 1;
          2: dly[i] = 3;
          3: dly[i] = TIMEOUT_A - 1;
          4: dly[i] = 255;
          default: dly[i] = 2;
        endcase
        sl[i] = int'($signed(16'($urandom)));
        sr[i] = int'($signed(16'($urandom)));
      end
      apply_cfg();
      run_mix($sformatf("rnd%0d", k));
    end

    // --------------------------------------------- overrun on dut_b
    rst_b_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (b_tick !== 1'b1 && n < 200);
    check("ovr:tick_wait", 64'(b_tick), 64'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (b_valid !== 1'b1 && n < 400);
    check("ovr:latency", 64'(n), 64'(2 + 1 + TIMEOUT_B + 3));
    check("ovr:overrun", 64'(b_ovr), 64'd1);
    check("ovr:terr",    64'(b_terr), 64'b0001);
    b_if.src_en = 4'b0000;
    nv = 0;
    for (int c = 0; c < 43; c++) begin
      @(negedge clk);
      if (b_valid) nv++;
    end
    check("ovr:queued_mixes", 64'(nv), 64'd1);
    check("ovr:sticky_ovr",   64'(b_ovr), 64'd1);
    check("ovr:sticky_terr",  64'(b_terr), 64'b0001);

    // ------------------------------------- reset during WAIT on dut_b
    b_if.src_en = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (b_if.src_req === 4'd0 && n < 200);
    check("rstw:in_wait", 64'(b_if.src_req), 64'b0001);
    rst_b_n = 1'b0;
    @(negedge clk);
    check("rstw:src_req", 64'(b_if.src_req), 64'd0);
    check("rstw:flags",   64'({b_terr, b_ovr}), 64'd0);
    check("rstw:outputs", 64'({b_left, b_right, b_valid, b_tick}), 64'd0);
    rst_b_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
